// File: rtl/swo_uart_rx_pkg.sv
// Shared constants for the SWO UART receiver.
// FSM encodings, frame shape and the default divisor floor.
package swo_uart_rx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int SWO_DATA_BITS = 8;
    localparam int SWO_STOP_BITS = 1;
    localparam int SWO_MIN_DIV   = 3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/swo_bit_sampler.sv
// SWO pin synchroniser, falling-edge detect and sample value.
// Build with SWO_RX_MAJORITY_EN for a 2-of-3 voted sample value.
module swo_bit_sampler
    import swo_uart_rx_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_swo,
    output logic o_line,
    output logic o_fall_edge
);

    (* ASYNC_REG = "TRUE" *) logic [1:0] r_sync;
    logic r_prev;
`ifdef SWO_RX_MAJORITY_EN
    logic r_prev2;
`endif

    // Two-flop synchroniser plus line history, idle-high after reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
`ifdef SWO_RX_MAJORITY_EN
            r_prev2 <= 1'b1;
`endif
        end else begin
            r_sync  <= {r_sync[0], i_swo};
            r_prev  <= r_sync[1];
`ifdef SWO_RX_MAJORITY_EN
            r_prev2 <= r_prev;
`endif
        end
    end

    // Edge detect always uses the raw synchronised line
    assign o_fall_edge = r_prev & ~r_sync[1];

    // Value the FSM samples at each sample point
`ifdef SWO_RX_MAJORITY_EN
    assign o_line = maj3(r_sync[1], r_prev, r_prev2);
`else
    assign o_line = r_sync[1];
`endif

endmodule

// File: rtl/swo_uart_rx.sv
// SWO 8N1 NRZ receiver with one-entry valid/ready output buffer.
// Optional macro SWO_RX_MAJORITY_EN selects 2-of-3 voted sampling.
module swo_uart_rx
    import swo_uart_rx_pkg::*;
#(
    parameter int pDIV_WIDTH = 8,
    parameter int pMIN_DIV   = SWO_MIN_DIV
) (
    input  logic                  uart_clk,
    input  logic                  reset_i,
    input  logic                  I_swo,
    input  logic                  I_swo_enable,
    input  logic [pDIV_WIDTH-1:0] I_bitrate_div,
    input  logic                  I_ready,
    input  logic                  I_clear_errors,
    output logic [7:0]            O_data,
    output logic                  O_valid,
    output logic                  O_busy,
    output logic                  O_framing_error,
    output logic                  O_overrun
);

    localparam logic [pDIV_WIDTH-1:0] LP_MIN = pDIV_WIDTH'(pMIN_DIV);
    localparam logic [2:0] LP_LAST = 3'(SWO_DATA_BITS - 1);

    logic                  w_line;
    logic                  w_fall;
    logic [pDIV_WIDTH-1:0] w_div_eff;
    logic                  w_ctr_zero;
    logic                  w_stop_hit;
    logic                  w_push;
    logic                  w_ferr;
    logic                  w_ovr;

    logic [1:0]            r_state;
    logic [pDIV_WIDTH-1:0] r_bit_ctr;
    logic [pDIV_WIDTH-1:0] r_div;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shreg;
    logic [7:0]            r_data;
    logic                  r_valid;
    logic                  r_fe;
    logic                  r_ovr;

    swo_bit_sampler u_sampler (
        .i_clk       (uart_clk),
        .i_rst       (reset_i),
        .i_swo       (I_swo),
        .o_line      (w_line),
        .o_fall_edge (w_fall)
    );

    assign w_div_eff  = (I_bitrate_div < LP_MIN) ? LP_MIN : I_bitrate_div;
    assign w_ctr_zero = (r_bit_ctr == '0);
    assign w_stop_hit = (r_state == ST_STOP) && w_ctr_zero && I_swo_enable;
    assign w_push     = w_stop_hit && w_line;
    assign w_ferr     = w_stop_hit && !w_line;
    assign w_ovr      = w_push && r_valid && !I_ready;

    // Frame FSM: start validation, data shifting, stop check
    always_ff @(posedge uart_clk) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_bit_ctr <= '0;
            r_div     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else if (r_state != ST_IDLE && !I_swo_enable) begin
            r_state <= ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (I_swo_enable && w_fall) begin
                        r_state   <= ST_START;
                        r_div     <= w_div_eff;
                        r_bit_ctr <= w_div_eff >> 1;
                    end
                end
                ST_START: begin
                    if (!w_ctr_zero) begin
                        r_bit_ctr <= r_bit_ctr - 1'b1;
                    end else if (!w_line) begin
                        r_state   <= ST_DATA;
                        r_bit_ctr <= r_div;
                        r_bit_idx <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!w_ctr_zero) begin
                        r_bit_ctr <= r_bit_ctr - 1'b1;
                    end else begin
                        r_shreg   <= {w_line, r_shreg[7:1]};
                        r_bit_ctr <= r_div;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == LP_LAST) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                default: begin
                    if (!w_ctr_zero) begin
                        r_bit_ctr <= r_bit_ctr - 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // One-entry output buffer; a push with a pending pop replaces it
    always_ff @(posedge uart_clk) begin
        if (reset_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_push) begin
            if (!r_valid || I_ready) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
            end
        end else if (r_valid && I_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new event beats a clear pulse
    always_ff @(posedge uart_clk) begin
        if (reset_i) begin
            r_fe  <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            if (w_ferr) begin
                r_fe <= 1'b1;
            end else if (I_clear_errors) begin
                r_fe <= 1'b0;
            end
            if (w_ovr) begin
                r_ovr <= 1'b1;
            end else if (I_clear_errors) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign O_data          = r_data;
    assign O_valid         = r_valid;
    assign O_busy          = (r_state != ST_IDLE);
    assign O_framing_error = r_fe;
    assign O_overrun       = r_ovr;

endmodule

// File: tb/tb_swo_uart_rx.sv
// Self-checking bench for swo_uart_rx.
// Honours SWO_RX_MAJORITY_EN for the spike-rejection expectation.
module tb_swo_uart_rx;

    logic       uart_clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       I_swo = 1'b1;
    logic       I_swo_enable = 1'b0;
    logic [7:0] I_bitrate_div = 8'd15;
    logic       I_ready = 1'b1;
    logic       I_clear_errors = 1'b0;
    logic [7:0] O_data;
    logic       O_valid;
    logic       O_busy;
    logic       O_framing_error;
    logic       O_overrun;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb_q[$];

    swo_uart_rx dut (
        .uart_clk        (uart_clk),
        .reset_i         (reset_i),
        .I_swo           (I_swo),
        .I_swo_enable    (I_swo_enable),
        .I_bitrate_div   (I_bitrate_div),
        .I_ready         (I_ready),
        .I_clear_errors  (I_clear_errors),
        .O_data          (O_data),
        .O_valid         (O_valid),
        .O_busy          (O_busy),
        .O_framing_error (O_framing_error),
        .O_overrun       (O_overrun)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed handshake pops one expected byte
    always @(negedge uart_clk) begin
        if (!reset_i && O_valid && I_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_byte: got %0h expected none", O_data);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                if (O_data !== e) begin
                    failures++;
                    $display("FAIL sb_data: got %0h expected %0h", O_data, e);
                end
            end
        end
    end

    function automatic int div_eff(input int div);
        return (div < 3) ? 3 : div;
    endfunction

    // Drive one frame cycle by cycle; index i = pin value after edge k+i
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int div, input int spike,
                              input int drop, input int rst,
                              output int vidx);
        int  d;
        int  per;
        int  n;
        logic b;
        d = div_eff(div);
        per = d + 1;
        I_bitrate_div = 8'(div);
        vidx = -1;
        @(posedge uart_clk); #1;
        for (int i = 0; i < 12 * per + 6; i++) begin
            n = i / per;
            if (n == 0) b = 1'b0;
            else if (n <= 8) b = data[n-1];
            else if (n == 9) b = stop;
            else b = 1'b1;
            if (i == spike) b = ~b;
            I_swo = b;
            if (vidx < 0 && O_valid) vidx = i;
            if (drop >= 0 && i == drop) I_swo_enable = 1'b0;
            if (drop >= 0 && i == drop + 1) chk("busy_after_drop", int'(O_busy), 0);
            if (i == rst) reset_i = 1'b1;
            @(posedge uart_clk); #1;
        end
        I_swo = 1'b1;
        reset_i = 1'b0;
    endtask

    task automatic clear_pulse();
        I_clear_errors = 1'b1;
        @(posedge uart_clk); #1;
        I_clear_errors = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         div;
        logic       exp_fe;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int vidx;
        int exp_idx;
        int busy_seen;
        logic [7:0] spike_exp;

        tbl[0] = '{8'hA5, 1'b1, 15,  1'b0};
        tbl[1] = '{8'h3C, 1'b0, 15,  1'b1};
        tbl[2] = '{8'h11, 1'b1, 15,  1'b0};
        tbl[3] = '{8'hFF, 1'b1, 1,   1'b0};
        tbl[4] = '{8'h00, 1'b1, 7,   1'b0};
        tbl[5] = '{8'h5A, 1'b1, 200, 1'b0};

        repeat (3) @(posedge uart_clk);
        #1;
        chk("rst_data", int'(O_data), 0);
        chk("rst_valid", int'(O_valid), 0);
        chk("rst_busy", int'(O_busy), 0);
        chk("rst_fe", int'(O_framing_error), 0);
        chk("rst_ovr", int'(O_overrun), 0);
        reset_i = 1'b0;
        I_swo_enable = 1'b1;
        repeat (4) @(posedge uart_clk);
        #1;

        // Table of frames with I_ready held high
        for (int t = 0; t < 6; t++) begin
            if (tbl[t].stop) sb_q.push_back(tbl[t].data);
            exp_idx = 4 + (div_eff(tbl[t].div) >> 1)
                      + 9 * (div_eff(tbl[t].div) + 1);
            send_frame(tbl[t].data, tbl[t].stop, tbl[t].div, -1, -1, -1, vidx);
            chk($sformatf("vec%0d_valid_at", t), vidx,
                tbl[t].stop ? exp_idx : -1);
            chk($sformatf("vec%0d_fe", t), int'(O_framing_error),
                int'(tbl[t].exp_fe));
            chk($sformatf("vec%0d_ovr", t), int'(O_overrun), 0);
            if (tbl[t].exp_fe) begin
                clear_pulse();
                chk($sformatf("vec%0d_fe_cleared", t), int'(O_framing_error), 0);
            end
        end

        // Overrun: second byte dropped while first is unconsumed
        I_ready = 1'b0;
        sb_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 15, -1, -1, -1, vidx);
        send_frame(8'h02, 1'b1, 15, -1, -1, -1, vidx);
        chk("ovr_data_held", int'(O_data), 8'h01);
        chk("ovr_valid", int'(O_valid), 1);
        chk("ovr_flag", int'(O_overrun), 1);
        I_ready = 1'b1;
        repeat (2) @(posedge uart_clk);
        #1;
        chk("ovr_drained", int'(O_valid), 0);
        clear_pulse();
        chk("ovr_cleared", int'(O_overrun), 0);

        // Three-cycle low glitch on an idle line
        I_bitrate_div = 8'd15;
        busy_seen = 0;
        I_swo = 1'b0;
        repeat (3) @(posedge uart_clk);
        #1;
        I_swo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (O_busy) busy_seen = 1;
            @(posedge uart_clk); #1;
        end
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_idle", int'(O_busy), 0);
        chk("glitch_no_valid", int'(O_valid), 0);
        chk("glitch_fe", int'(O_framing_error), 0);

        // Clamped divisor, then enable dropped during data bit 3
        sb_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 1, -1, -1, -1, vidx);
        chk("clamp_valid_at", vidx, 41);
        send_frame(8'h00, 1'b1, 1, -1, 18, -1, vidx);
        chk("drop_no_valid", vidx, -1);
        chk("drop_fe", int'(O_framing_error), 0);
        I_swo_enable = 1'b1;
        repeat (4) @(posedge uart_clk);
        #1;

        // One-cycle spike at the data bit 4 sample point
`ifdef SWO_RX_MAJORITY_EN
        spike_exp = 8'h00;
`else
        spike_exp = 8'h10;
`endif
        sb_q.push_back(spike_exp);
        send_frame(8'h00, 1'b1, 15, 88, -1, -1, vidx);
        chk("spike_valid_at", vidx, 155);

        // Reset mid-frame loses the buffered byte
        I_ready = 1'b0;
        send_frame(8'h55, 1'b1, 15, -1, -1, -1, vidx);
        chk("pre_rst_valid", int'(O_valid), 1);
        send_frame(8'h66, 1'b1, 15, -1, -1, 50, vidx);
        chk("midrst_valid", int'(O_valid), 0);
        chk("midrst_data", int'(O_data), 0);
        chk("midrst_busy", int'(O_busy), 0);
        chk("midrst_ovr", int'(O_overrun), 0);
        I_ready = 1'b1;
        repeat (4) @(posedge uart_clk);
        #1;

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
